// File: rtl/bit_serial_alu_ctrl_if.sv
// Request/response bundle between a host and the bit-serial ALU controller.
// The host drives the operation request; the controller returns status and the latched result.
interface bit_serial_alu_ctrl_if;
  logic        start;
  logic [3:0]  alu_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        overflow;

  modport master (
    output start, alu_op, src_a, src_b,
    input  busy, done, result, zero, overflow
  );

  modport slave (
    input  start, alu_op, src_a, src_b,
    output busy, done, result, zero, overflow
  );
endinterface

// File: rtl/bit_serial_alu_ctrl.sv
// Controller that runs a 32-bit ALU operation through an external 1-bit ALU slice,
// one bit per cycle (LSB first), then fixes up SLT and the status flags.
module bit_serial_alu_ctrl (
  input  logic                        clk,
  input  logic                        rst_n,
  bit_serial_alu_ctrl_if.slave        bus,
  output logic                        slice_a,
  output logic                        slice_b,
  output logic                        slice_less,
  output logic                        slice_a_invert,
  output logic                        slice_b_invert,
  output logic                        slice_carry_in,
  output logic [1:0]                  slice_operation,
  input  logic                        slice_result,
  input  logic                        slice_carry_out
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Returns {supported, a_invert, b_invert, operation[1:0]}
  function automatic logic [4:0] op_decode(input logic [3:0] op);
    logic [4:0] d;
    case (op)
      OP_AND:  d = 5'b1_0_0_00;
      OP_OR:   d = 5'b1_0_0_01;
      OP_ADD:  d = 5'b1_0_0_10;
      OP_SUB:  d = 5'b1_0_1_10;
      OP_SLT:  d = 5'b1_0_1_10;
      OP_NOR:  d = 5'b1_1_1_00;
      default: d = 5'b0_0_0_00;
    endcase
    return d;
  endfunction

  function automatic logic op_b_invert(input logic [3:0] op);
    logic b;
    case (op)
      OP_SUB:  b = 1'b1;
      OP_SLT:  b = 1'b1;
      OP_NOR:  b = 1'b1;
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_shift;
  logic        r_carry;
  logic [4:0]  r_cnt;
  logic [31:0] r_result;
  logic        r_zero;
  logic        r_ovf;
  logic        r_busy;
  logic        r_done;

  logic [4:0]  w_dec;
  logic        w_run;
  logic        w_v;
  logic [31:0] w_shift_next;
  logic [31:0] w_final;
  logic        w_ovf_final;

  assign w_dec        = op_decode(r_op);
  assign w_run        = (r_state == ST_RUN);
  assign w_v          = r_carry ^ slice_carry_out;
  assign w_shift_next = {slice_result, r_shift[31:1]};

  // Slice drive is gated by RUN so the slice sees all zeros otherwise
  assign slice_a         = w_run & r_a[0];
  assign slice_b         = w_run & r_b[0];
  assign slice_less      = 1'b0;
  assign slice_a_invert  = w_run & w_dec[3];
  assign slice_b_invert  = w_run & w_dec[2];
  assign slice_carry_in  = w_run & r_carry;
  assign slice_operation = w_run ? w_dec[1:0] : 2'b00;

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.result   = r_result;
  assign bus.zero     = r_zero;
  assign bus.overflow = r_ovf;

  // Final result and overflow as captured on the last RUN cycle
  always_comb begin
    w_final     = 32'd0;
    w_ovf_final = 1'b0;
    if (w_dec[4] == 1'b0) begin
      w_final = 32'd0;
    end else if (r_op == OP_SLT) begin
      w_final = {31'd0, slice_result ^ w_v};
    end else begin
      w_final = w_shift_next;
    end
    if ((r_op == OP_ADD) || (r_op == OP_SUB)) begin
      w_ovf_final = w_v;
    end else begin
      w_ovf_final = 1'b0;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_cnt == 5'd31) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register with registered busy/done derived from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != ST_IDLE);
      r_done  <= (w_state_next == ST_DONE);
    end
  end

  // Operand capture, serial datapath and flag update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op     <= 4'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_shift  <= 32'd0;
      r_carry  <= 1'b0;
      r_cnt    <= 5'd0;
      r_result <= 32'd0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_op    <= bus.alu_op;
            r_a     <= bus.src_a;
            r_b     <= bus.src_b;
            r_shift <= 32'd0;
            r_cnt   <= 5'd0;
            r_carry <= op_b_invert(bus.alu_op);
          end
        end
        ST_RUN: begin
          r_shift <= w_shift_next;
          r_a     <= {1'b0, r_a[31:1]};
          r_b     <= {1'b0, r_b[31:1]};
          r_carry <= slice_carry_out;
          r_cnt   <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_result <= w_final;
            r_zero   <= (w_final == 32'd0);
            r_ovf    <= w_ovf_final;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Bench for bit_serial_alu_ctrl: models the external 1-bit slice and checks each operation
// against a word-level arithmetic reference.
module tb_bit_serial_alu_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic s_a, s_b, s_less, s_ainv, s_binv, s_cin, s_res, s_cout, s_ea, s_eb;
  logic [1:0] s_op;
  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;

  bit_serial_alu_ctrl_if bus ();

  bit_serial_alu_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .slice_a         (s_a),
    .slice_b         (s_b),
    .slice_less      (s_less),
    .slice_a_invert  (s_ainv),
    .slice_b_invert  (s_binv),
    .slice_carry_in  (s_cin),
    .slice_operation (s_op),
    .slice_result    (s_res),
    .slice_carry_out (s_cout)
  );

  always #5 clk = ~clk;

  // External 1-bit ALU slice
  assign s_ea   = s_a ^ s_ainv;
  assign s_eb   = s_b ^ s_binv;
  assign s_res  = (s_op == 2'b00) ? (s_ea & s_eb) :
                  (s_op == 2'b01) ? (s_ea | s_eb) :
                  (s_op == 2'b10) ? (s_ea ^ s_eb ^ s_cin) : s_less;
  assign s_cout = (s_ea & s_eb) | (s_ea & s_cin) | (s_eb & s_cin);

  always @(negedge clk) if (bus.done === 1'b1) n_done++;

  // Word-level reference: returns {overflow, result}
  function automatic logic [32:0] ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic v;
    r = 32'd0;
    v = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'b0110: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: r = ~(a | b);
      default: r = 32'd0;
    endcase
    return {v, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, " done"}, {31'd0, bus.done}, 32'd0);
    check({tag, " slices"}, {25'd0, s_a, s_b, s_less, s_ainv, s_binv, s_cin, s_op[1], s_op[0]}, 32'd0);
  endtask

  // Runs one operation; inject_cyc >= 0 pulses a spurious start at that RUN cycle
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int inject_cyc);
    logic [32:0] exp;
    logic        exp_binv;
    int          d0;
    exp      = ref_model(op, a, b);
    exp_binv = (op == 4'b0110) || (op == 4'b0111) || (op == 4'b1100);
    d0       = n_done;
    bus.start = 1'b1; bus.alu_op = op; bus.src_a = a; bus.src_b = b;
    tick();
    bus.start = 1'b0;
    check("run busy", {31'd0, bus.busy}, 32'd1);
    check("run slice a/b", {30'd0, s_a, s_b}, {30'd0, a[0], b[0]});
    check("run carry_in", {31'd0, s_cin}, {31'd0, exp_binv});
    for (int c = 1; c <= 31; c++) begin
      bus.alu_op = 4'($urandom);
      bus.src_a  = $urandom;
      bus.src_b  = $urandom;
      bus.start  = (c - 1 == inject_cyc) ? 1'b1 : 1'b0;
      tick();
      bus.start  = 1'b0;
    end
    check("no early done", {31'd0, bus.done}, 32'd0);
    check("no early pulse", n_done, d0);
    tick();
    check("done at latency", {31'd0, bus.done}, 32'd1);
    check("busy in done", {31'd0, bus.busy}, 32'd1);
    check("result", bus.result, exp[31:0]);
    check("zero", {31'd0, bus.zero}, {31'd0, (exp[31:0] == 32'd0)});
    check("overflow", {31'd0, bus.overflow}, {31'd0, exp[32]});
    tick();
    check_idle_outputs("after done");
    check("result held", bus.result, exp[31:0]);
    check("one done pulse", n_done, d0 + 1);
  endtask

  initial begin
    logic [3:0]  ops [6];
    logic [3:0]  op;
    logic [31:0] a, b;
    int          d0;
    ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010;
    ops[3] = 4'b0110; ops[4] = 4'b0111; ops[5] = 4'b1100;

    rst_n = 1'b0;
    bus.start = 1'b1; bus.alu_op = 4'b0010; bus.src_a = 32'd1; bus.src_b = 32'd1;
    tick();
    tick();
    check_idle_outputs("reset");
    check("reset result", bus.result, 32'd0);
    check("reset flags", {30'd0, bus.zero, bus.overflow}, 32'd0);
    rst_n = 1'b1;
    bus.start = 1'b0;
    tick();
    check("start in reset ignored", {31'd0, bus.busy}, 32'd0);

    run_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, -1);
    run_op(4'b0110, 32'h0000_0005, 32'h0000_0005, -1);
    run_op(4'b0110, 32'h8000_0000, 32'h0000_0001, -1);
    run_op(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, -1);
    run_op(4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, -1);
    run_op(4'b1100, 32'h0000_0000, 32'h0F0F_0F0F, -1);
    run_op(4'b0000, 32'hA5A5_A5A5, 32'h0F0F_0F0F, -1);
    run_op(4'b0001, 32'hA5A5_A5A5, 32'h0F0F_0F0F, -1);
    run_op(4'b0010, 32'h1234_5678, 32'h1111_1111, 10);
    run_op(4'b1010, 32'hDEAD_BEEF, 32'h0000_0001, -1);

    // Abort by reset at RUN cycle 12
    d0 = n_done;
    bus.start = 1'b1; bus.alu_op = 4'b0010; bus.src_a = 32'h0000_0100; bus.src_b = 32'h0000_0200;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 12; c++) tick();
    rst_n = 1'b0;
    bus.start = 1'b1;
    tick();
    rst_n = 1'b1;
    bus.start = 1'b0;
    check_idle_outputs("abort");
    check("abort result", bus.result, 32'd0);
    check("abort flags", {30'd0, bus.zero, bus.overflow}, 32'd0);
    for (int c = 0; c < 36; c++) tick();
    check("abort no done", n_done, d0);
    check("abort stays idle", {31'd0, bus.busy}, 32'd0);
    run_op(4'b0010, 32'd3, 32'd4, -1);

    for (int i = 0; i < 14; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom) : ops[$urandom_range(0, 5)];
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 3))
        0: a = 32'h7FFF_FFFF;
        1: b = 32'h8000_0000;
        2: b = a;
        default: b = b ^ 32'h0000_0000;
      endcase
      run_op(op, a, b, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
